// File: rtl/multi_vc_input_buffer.sv
// Input-port buffer bank: NUM_VC independent flit FIFOs behind one link, each with a
// write-order checker, a VA/SA request FSM and one credit returned per popped flit.
module multi_vc_input_buffer #(
    parameter int NUM_VC      = 4,
    parameter int BUFFER_SIZE = 4,
    parameter int DATA_W      = 16,
    parameter int PORT_W      = 3,
    localparam int VC_SIZE    = $clog2(NUM_VC),
    localparam int FLIT_W     = DATA_W + 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_W-1:0]           data_i,
    input  logic                        write_i,
    input  logic [VC_SIZE-1:0]          wr_vc_i,
    input  logic [PORT_W-1:0]           out_port_i,
    input  logic [NUM_VC-1:0]           vc_valid_i,
    input  logic [NUM_VC*VC_SIZE-1:0]   vc_new_i,
    input  logic [NUM_VC-1:0]           read_i,
    output logic [FLIT_W-1:0]           data_o,
    output logic                        data_valid_o,
    output logic [VC_SIZE-1:0]          rd_vc_o,
    output logic [NUM_VC*FLIT_W-1:0]    peek_o,
    output logic [NUM_VC-1:0]           is_full_o,
    output logic [NUM_VC-1:0]           is_empty_o,
    output logic [NUM_VC*PORT_W-1:0]    out_port_o,
    output logic [NUM_VC*VC_SIZE-1:0]   downstream_vc_o,
    output logic [NUM_VC-1:0]           vc_request_o,
    output logic [NUM_VC-1:0]           switch_request_o,
    output logic [NUM_VC-1:0]           vc_allocatable_o,
    output logic                        credit_o,
    output logic [VC_SIZE-1:0]          credit_vc_o,
    output logic [NUM_VC-1:0]           error_o
);

    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;

    // Flit layout: {type[1:0], payload}; type 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL.
    localparam logic [1:0] FT_HEAD     = 2'b00;
    localparam logic [1:0] FT_TAIL     = 2'b10;
    localparam logic [1:0] FT_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_VA, ST_ACTIVE} state_t;

    logic [1:0]                 wr_type;
    logic                       wr_is_head;
    logic                       read_legal;
    logic [NUM_VC-1:0]          pop;
    logic [VC_SIZE-1:0]         rd_vc;
    logic [NUM_VC*FLIT_W-1:0]   front_flat;

    assign wr_type    = data_i[FLIT_W-1 -: 2];
    assign wr_is_head = (wr_type == FT_HEAD) || (wr_type == FT_HEADTAIL);

    // A pop happens only for a one-hot read aimed at a VC that is requesting the switch.
    assign read_legal = $onehot(read_i) && ((read_i & switch_request_o) != '0);
    assign pop        = read_legal ? read_i : '0;

    always_comb begin
        rd_vc = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (read_i[i]) begin
                rd_vc = VC_SIZE'(i);
            end
        end
    end

    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
        logic [FLIT_W-1:0]  mem [BUFFER_SIZE];
        logic [PTR_W-1:0]   wr_ptr_reg;
        logic [PTR_W-1:0]   rd_ptr_reg;
        logic [CNT_W-1:0]   cnt_reg;
        logic               in_pkt_reg;
        logic               error_reg;
        logic [PORT_W-1:0]  out_port_reg;
        logic [VC_SIZE-1:0] ds_vc_reg;
        state_t             state_reg;
        logic               wr_sel;
        logic               type_ok;
        logic               space_ok;
        logic               push;
        logic               empty;
        logic [1:0]         front_type;

        assign wr_sel     = write_i && (wr_vc_i == VC_SIZE'(gi));
        assign type_ok    = wr_is_head ? !in_pkt_reg : in_pkt_reg;
        // A full VC still accepts a write when the same edge pops it.
        assign space_ok   = (cnt_reg != CNT_W'(BUFFER_SIZE)) || pop[gi];
        assign push       = wr_sel && type_ok && space_ok;
        assign empty      = (cnt_reg == '0);
        assign front_type = mem[rd_ptr_reg][FLIT_W-1 -: 2];

        always_ff @(posedge clk) begin
            if (push) begin
                mem[wr_ptr_reg] <= data_i;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                wr_ptr_reg   <= '0;
                rd_ptr_reg   <= '0;
                cnt_reg      <= '0;
                in_pkt_reg   <= 1'b0;
                error_reg    <= 1'b0;
                out_port_reg <= '0;
                ds_vc_reg    <= '0;
                state_reg    <= ST_IDLE;
            end else begin
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    if (wr_is_head) begin
                        out_port_reg <= out_port_i;
                    end
                    if (wr_type == FT_HEAD) begin
                        in_pkt_reg <= 1'b1;
                    end else if (wr_type == FT_TAIL) begin
                        in_pkt_reg <= 1'b0;
                    end
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                cnt_reg <= cnt_reg + CNT_W'(push) - CNT_W'(pop[gi]);
                if ((wr_sel && !push) || (read_i[gi] && !read_legal)) begin
                    error_reg <= 1'b1;
                end
                case (state_reg)
                    ST_IDLE: begin
                        if (!empty) begin
                            state_reg <= ST_VA;
                        end
                    end
                    ST_VA: begin
                        if (vc_valid_i[gi]) begin
                            ds_vc_reg <= vc_new_i[gi*VC_SIZE +: VC_SIZE];
                            state_reg <= ST_ACTIVE;
                        end
                    end
                    ST_ACTIVE: begin
                        if (pop[gi] && ((front_type == FT_TAIL) || (front_type == FT_HEADTAIL))) begin
                            state_reg <= ST_IDLE;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end

        assign front_flat[gi*FLIT_W +: FLIT_W]        = mem[rd_ptr_reg];
        assign peek_o[gi*FLIT_W +: FLIT_W]            = empty ? '0 : mem[rd_ptr_reg];
        assign is_full_o[gi]                          = (cnt_reg == CNT_W'(BUFFER_SIZE));
        assign is_empty_o[gi]                         = empty;
        assign out_port_o[gi*PORT_W +: PORT_W]        = out_port_reg;
        assign downstream_vc_o[gi*VC_SIZE +: VC_SIZE] = ds_vc_reg;
        assign vc_request_o[gi]                       = (state_reg == ST_VA);
        assign switch_request_o[gi]                   = (state_reg == ST_ACTIVE) && !empty;
        assign vc_allocatable_o[gi]                   = (state_reg == ST_IDLE) && empty;
        assign error_o[gi]                            = error_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
            rd_vc_o      <= '0;
            credit_o     <= 1'b0;
            credit_vc_o  <= '0;
        end else begin
            data_valid_o <= read_legal;
            credit_o     <= read_legal;
            if (read_legal) begin
                data_o      <= front_flat[rd_vc*FLIT_W +: FLIT_W];
                rd_vc_o     <= rd_vc;
                credit_vc_o <= rd_vc;
            end
        end
    end

endmodule

// File: tb/tb_multi_vc_input_buffer.sv
// Self-checking bench for multi_vc_input_buffer: a directed vector table, hand-written
// corner sequences and a randomized run, all scored against a queue-based reference model.
module tb_multi_vc_input_buffer;

    localparam int NV = 4;
    localparam int BS = 4;
    localparam int DW = 16;
    localparam int PW = 3;
    localparam int VS = 2;
    localparam int FW = DW + 2;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FW-1:0]     data_i;
    logic              write_i;
    logic [VS-1:0]     wr_vc_i;
    logic [PW-1:0]     out_port_i;
    logic [NV-1:0]     vc_valid_i;
    logic [NV*VS-1:0]  vc_new_i;
    logic [NV-1:0]     read_i;
    logic [FW-1:0]     data_o;
    logic              data_valid_o;
    logic [VS-1:0]     rd_vc_o;
    logic [NV*FW-1:0]  peek_o;
    logic [NV-1:0]     is_full_o;
    logic [NV-1:0]     is_empty_o;
    logic [NV*PW-1:0]  out_port_o;
    logic [NV*VS-1:0]  downstream_vc_o;
    logic [NV-1:0]     vc_request_o;
    logic [NV-1:0]     switch_request_o;
    logic [NV-1:0]     vc_allocatable_o;
    logic              credit_o;
    logic [VS-1:0]     credit_vc_o;
    logic [NV-1:0]     error_o;

    always #5 clk = ~clk;

    multi_vc_input_buffer #(
        .NUM_VC(NV), .BUFFER_SIZE(BS), .DATA_W(DW), .PORT_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .write_i(write_i), .wr_vc_i(wr_vc_i),
        .out_port_i(out_port_i), .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i),
        .read_i(read_i), .data_o(data_o), .data_valid_o(data_valid_o), .rd_vc_o(rd_vc_o),
        .peek_o(peek_o), .is_full_o(is_full_o), .is_empty_o(is_empty_o),
        .out_port_o(out_port_o), .downstream_vc_o(downstream_vc_o),
        .vc_request_o(vc_request_o), .switch_request_o(switch_request_o),
        .vc_allocatable_o(vc_allocatable_o), .credit_o(credit_o),
        .credit_vc_o(credit_vc_o), .error_o(error_o)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: per-VC flit queue, packet flag and allocation phase
    // (0 = waiting for a flit, 1 = asking for a downstream VC, 2 = holding one).
    logic [FW-1:0] mq [NV][$];
    int            mphase [NV];
    bit            min_pkt [NV];
    logic [VS-1:0] mds [NV];
    logic [PW-1:0] mport [NV];
    bit [NV-1:0]   merr;
    bit            mdv;
    bit            mcred;
    logic [FW-1:0] mdata;
    logic [VS-1:0] mrdvc;

    typedef struct {
        logic        wr;
        logic [1:0]  vc;
        logic [1:0]  t;
        logic [15:0] pl;
        logic        gnt;
        logic [1:0]  nv;
        logic [3:0]  rd;
        logic [3:0]  e_vreq;
        logic [3:0]  e_sw;
        logic [3:0]  e_alloc;
        logic        e_dv;
        logic [17:0] e_data;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            mq[v].delete();
            mphase[v]  = 0;
            min_pkt[v] = 1'b0;
            mds[v]     = '0;
            mport[v]   = '0;
        end
        merr  = '0;
        mdv   = 1'b0;
        mcred = 1'b0;
        mdata = '0;
        mrdvc = '0;
    endtask

    function automatic bit [NV-1:0] model_sw();
        bit [NV-1:0] sw;
        for (int v = 0; v < NV; v++) begin
            sw[v] = (mphase[v] == 2) && (mq[v].size() > 0);
        end
        return sw;
    endfunction

    task automatic model_step();
        int            sz [NV];
        bit [NV-1:0]   sw;
        bit            legal;
        bit            tail;
        bit            head;
        int            rv;
        int            wv;
        logic [FW-1:0] f;
        logic [1:0]    t;
        if (!rst) begin
            model_reset();
            return;
        end
        sw = model_sw();
        for (int v = 0; v < NV; v++) begin
            sz[v] = mq[v].size();
        end
        legal = ($countones(read_i) == 1) && ((read_i & sw) != '0);
        rv = 0;
        for (int v = 0; v < NV; v++) begin
            if (read_i[v]) rv = v;
            if (read_i[v] && !legal) merr[v] = 1'b1;
        end
        mdv = 1'b0;
        mcred = 1'b0;
        tail = 1'b0;
        if (legal) begin
            f = mq[rv].pop_front();
            mdv = 1'b1;
            mcred = 1'b1;
            mdata = f;
            mrdvc = VS'(rv);
            tail = (f[FW-1:FW-2] == T_TAIL) || (f[FW-1:FW-2] == T_HT);
        end
        if (write_i) begin
            wv = int'(wr_vc_i);
            t = data_i[FW-1:FW-2];
            head = (t == T_HEAD) || (t == T_HT);
            if ((head ? !min_pkt[wv] : min_pkt[wv]) && ((sz[wv] < BS) || (legal && rv == wv))) begin
                mq[wv].push_back(data_i);
                if (head) mport[wv] = out_port_i;
                if (t == T_HEAD) min_pkt[wv] = 1'b1;
                else if (t == T_TAIL) min_pkt[wv] = 1'b0;
            end else begin
                merr[wv] = 1'b1;
            end
        end
        for (int v = 0; v < NV; v++) begin
            case (mphase[v])
                0: if (sz[v] > 0) mphase[v] = 1;
                1: if (vc_valid_i[v]) begin
                    mphase[v] = 2;
                    mds[v] = vc_new_i[v*VS +: VS];
                end
                default: if (legal && rv == v && tail) mphase[v] = 0;
            endcase
        end
    endtask

    task automatic check_all();
        logic [NV-1:0]    e_empty;
        logic [NV-1:0]    e_full;
        logic [NV-1:0]    e_vreq;
        logic [NV-1:0]    e_sw;
        logic [NV-1:0]    e_alloc;
        logic [NV*FW-1:0] e_peek;
        logic [NV*PW-1:0] e_port;
        logic [NV*VS-1:0] e_ds;
        for (int v = 0; v < NV; v++) begin
            e_empty[v] = (mq[v].size() == 0);
            e_full[v]  = (mq[v].size() == BS);
            e_vreq[v]  = (mphase[v] == 1);
            e_sw[v]    = (mphase[v] == 2) && (mq[v].size() > 0);
            e_alloc[v] = (mphase[v] == 0) && (mq[v].size() == 0);
            e_peek[v*FW +: FW] = (mq[v].size() > 0) ? mq[v][0] : '0;
            e_port[v*PW +: PW] = mport[v];
            e_ds[v*VS +: VS]   = mds[v];
        end
        chk("is_empty_o", is_empty_o, e_empty);
        chk("is_full_o", is_full_o, e_full);
        chk("vc_request_o", vc_request_o, e_vreq);
        chk("switch_request_o", switch_request_o, e_sw);
        chk("vc_allocatable_o", vc_allocatable_o, e_alloc);
        chk("peek_o", peek_o, e_peek);
        chk("out_port_o", out_port_o, e_port);
        chk("downstream_vc_o", downstream_vc_o, e_ds);
        chk("error_o", error_o, merr);
        chk("data_valid_o", data_valid_o, mdv);
        chk("credit_o", credit_o, mcred);
        if (mdv) begin
            chk("data_o", data_o, mdata);
            chk("rd_vc_o", rd_vc_o, mrdvc);
            chk("credit_vc_o", credit_vc_o, mrdvc);
        end
    endtask

    task automatic set_idle();
        data_i     = '0;
        write_i    = 1'b0;
        wr_vc_i    = '0;
        out_port_i = '0;
        vc_valid_i = '0;
        vc_new_i   = '0;
        read_i     = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        set_idle();
    endtask

    task automatic set_wr(input int vc, input logic [1:0] t, input logic [15:0] pl,
                          input logic [2:0] port);
        write_i    = 1'b1;
        wr_vc_i    = VS'(vc);
        data_i     = {t, pl};
        out_port_i = port;
    endtask

    task automatic set_grant(input int vc, input logic [1:0] nv);
        vc_valid_i[vc] = 1'b1;
        vc_new_i[vc*VS +: VS] = nv;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " is_empty_o"}, is_empty_o, 4'hF);
        chk({tag, " vc_allocatable_o"}, vc_allocatable_o, 4'hF);
        chk({tag, " is_full_o"}, is_full_o, 4'h0);
        chk({tag, " vc_request_o"}, vc_request_o, 4'h0);
        chk({tag, " switch_request_o"}, switch_request_o, 4'h0);
        chk({tag, " error_o"}, error_o, 4'h0);
        chk({tag, " data_valid_o"}, data_valid_o, 1'b0);
        chk({tag, " credit_o"}, credit_o, 1'b0);
        chk({tag, " data_o"}, data_o, 18'h0);
        chk({tag, " rd_vc_o"}, rd_vc_o, 2'd0);
        chk({tag, " credit_vc_o"}, credit_vc_o, 2'd0);
        chk({tag, " peek_o"}, peek_o, 72'h0);
        chk({tag, " out_port_o"}, out_port_o, 12'h0);
        chk({tag, " downstream_vc_o"}, downstream_vc_o, 8'h0);
    endtask

    initial begin
        // Single packet through VC2: write, allocate, drain (granted downstream VC 3).
        tv[0] = '{1'b1, 2'd2, T_HEAD, 16'hA001, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1011, 1'b0, 18'h0};
        tv[1] = '{1'b1, 2'd2, T_BODY, 16'hB002, 1'b0, 2'd0, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 1'b0, 18'h0};
        tv[2] = '{1'b1, 2'd2, T_TAIL, 16'hC003, 1'b0, 2'd0, 4'b0000, 4'b0100, 4'b0000, 4'b1011, 1'b0, 18'h0};
        tv[3] = '{1'b0, 2'd0, T_HEAD, 16'h0000, 1'b1, 2'd3, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 1'b0, 18'h0};
        tv[4] = '{1'b0, 2'd0, T_HEAD, 16'h0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 1'b1, 18'h0A001};
        tv[5] = '{1'b0, 2'd0, T_HEAD, 16'h0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0100, 4'b1011, 1'b1, 18'h1B002};
        tv[6] = '{1'b0, 2'd0, T_HEAD, 16'h0000, 1'b0, 2'd0, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 1'b1, 18'h2C003};
        tv[7] = '{1'b0, 2'd0, T_HEAD, 16'h0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0, 18'h0};

        model_reset();
        set_idle();
        rst = 1'b0;
        step();
        step();
        check_reset_vals("init");
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (tv[i].wr) set_wr(int'(tv[i].vc), tv[i].t, tv[i].pl, 3'd5);
            if (tv[i].gnt) set_grant(2, tv[i].nv);
            read_i = tv[i].rd;
            step();
            chk($sformatf("tv%0d vc_request_o", i), vc_request_o, tv[i].e_vreq);
            chk($sformatf("tv%0d switch_request_o", i), switch_request_o, tv[i].e_sw);
            chk($sformatf("tv%0d vc_allocatable_o", i), vc_allocatable_o, tv[i].e_alloc);
            chk($sformatf("tv%0d data_valid_o", i), data_valid_o, tv[i].e_dv);
            chk($sformatf("tv%0d credit_o", i), credit_o, tv[i].e_dv);
            chk($sformatf("tv%0d error_o", i), error_o, 4'h0);
            if (tv[i].e_dv) begin
                chk($sformatf("tv%0d data_o", i), data_o, tv[i].e_data);
                chk($sformatf("tv%0d credit_vc_o", i), credit_vc_o, 2'd2);
            end
            if (i == 3) chk("tv3 downstream_vc_o[2]", downstream_vc_o[4 +: 2], 2'd3);
        end
        chk("tbl out_port_o[2]", out_port_o[6 +: 3], 3'd5);

        // Interleaved HEADTAIL on VC0 and a 3-flit packet on VC1, grants VC1 first.
        reset_dut();
        set_wr(0, T_HT, 16'h1111, 3'd1); step();
        set_wr(1, T_HEAD, 16'h2222, 3'd2); step();
        set_wr(1, T_BODY, 16'h3333, 3'd0); step();
        set_wr(1, T_TAIL, 16'h4444, 3'd0); step();
        set_grant(1, 2'd0); step();
        set_grant(0, 2'd3); step();
        read_i = 4'b0010; step();
        chk("ilv vc1 head", data_o, {T_HEAD, 16'h2222});
        read_i = 4'b0001; step();
        chk("ilv vc0 headtail", data_o, {T_HT, 16'h1111});
        chk("ilv rd_vc_o", rd_vc_o, 2'd0);
        read_i = 4'b0010; step();
        chk("ilv vc1 body", data_o, {T_BODY, 16'h3333});
        read_i = 4'b0010; step();
        chk("ilv vc1 tail", data_o, {T_TAIL, 16'h4444});
        chk("ilv error_o", error_o, 4'h0);
        chk("ilv vc_allocatable_o", vc_allocatable_o, 4'hF);

        // Overflow on a full VC, then full-VC write accepted alongside a pop.
        reset_dut();
        set_wr(1, T_HEAD, 16'h0100, 3'd3); step();
        for (int k = 0; k < BS - 1; k++) begin
            set_wr(1, T_BODY, 16'(k), 3'd0); step();
        end
        chk("full is_full_o[1]", is_full_o[1], 1'b1);
        set_wr(1, T_BODY, 16'h0BAD, 3'd0); step();
        chk("overflow error_o", error_o, 4'b0010);
        reset_dut();
        set_wr(1, T_HEAD, 16'h0200, 3'd3); step();
        for (int k = 0; k < BS - 1; k++) begin
            set_wr(1, T_BODY, 16'(k), 3'd0); step();
        end
        set_grant(1, 2'd1); step();
        set_wr(1, T_TAIL, 16'h0E0D, 3'd0);
        read_i = 4'b0010;
        step();
        chk("rw full is_full_o[1]", is_full_o[1], 1'b1);
        chk("rw full error_o", error_o, 4'h0);
        chk("rw full data_o", data_o, {T_HEAD, 16'h0200});

        // Ordering violations.
        reset_dut();
        set_wr(3, T_HEAD, 16'h3000, 3'd1); step();
        set_wr(3, T_HEAD, 16'h3001, 3'd2); step();
        chk("dup head error_o", error_o, 4'b1000);
        set_wr(0, T_BODY, 16'h0001, 3'd0); step();
        chk("idle body error_o", error_o, 4'b1001);

        // Illegal reads: multi-hot, then an empty ACTIVE VC.
        reset_dut();
        set_wr(0, T_HT, 16'h0A0A, 3'd1); step();
        set_wr(1, T_HT, 16'h0B0B, 3'd2); step();
        set_grant(0, 2'd1); step();
        set_grant(1, 2'd2); step();
        read_i = 4'b0011; step();
        chk("multihot error_o", error_o, 4'b0011);
        chk("multihot data_valid_o", data_valid_o, 1'b0);
        set_wr(2, T_HEAD, 16'h0C0C, 3'd4); step();
        step();
        set_grant(2, 2'd0); step();
        read_i = 4'b0100; step();
        chk("pop head data_valid_o", data_valid_o, 1'b1);
        read_i = 4'b0100; step();
        chk("empty read credit_o", credit_o, 1'b0);
        chk("empty read error_o", error_o, 4'b0111);

        // Reset mid-packet with a pending read.
        reset_dut();
        set_wr(0, T_HEAD, 16'h5555, 3'd6); step();
        set_wr(0, T_BODY, 16'h6666, 3'd0); step();
        set_grant(0, 2'd2); step();
        read_i = 4'b0001;
        rst = 1'b0;
        step();
        check_reset_vals("midrst");
        rst = 1'b1;
        step();
        chk("midrst credit_o", credit_o, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            int          v;
            logic [1:0]  t;
            bit [NV-1:0] sw;
            if ($urandom_range(99, 0) < 60) begin
                v = int'($urandom_range(NV - 1, 0));
                if ($urandom_range(19, 0) == 0) t = 2'($urandom);
                else if (min_pkt[v]) t = ($urandom_range(1, 0) == 1) ? T_BODY : T_TAIL;
                else t = ($urandom_range(3, 0) == 0) ? T_HT : T_HEAD;
                set_wr(v, t, 16'($urandom), 3'($urandom));
            end
            for (int g = 0; g < NV; g++) begin
                if ($urandom_range(3, 0) == 0) set_grant(g, 2'($urandom));
            end
            sw = model_sw();
            if (sw != '0 && $urandom_range(99, 0) < 70) begin
                do v = int'($urandom_range(NV - 1, 0)); while (!sw[v]);
                read_i = NV'(1) << v;
            end else if ($urandom_range(29, 0) == 0) begin
                read_i = NV'($urandom);
            end
            if ($urandom_range(199, 0) == 0) rst = 1'b0;
            step();
            rst = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
